// File: rtl/ioctl_ddram_loader_pkg.sv
// Shared types and constants for the ioctl-to-DDRAM cartridge loader.
package ioctl_ddram_loader_pkg;

  localparam int unsigned DDR_WORD_W   = 64;
  localparam int unsigned DDR_ADDR_W   = 29;
  localparam int unsigned DDR_BE_W     = 8;
  localparam int unsigned IOCTL_ADDR_W = 25;
  localparam int unsigned WORD_IDX_W   = 22;

  localparam logic [7:0]              CART_INDEX      = 8'd1;
  localparam logic [DDR_ADDR_W-1:0]   CART_BASE_WADDR = 29'h03C0_0000;
  localparam logic [IOCTL_ADDR_W-1:0] CART_MAX_BYTES  = 25'h1F_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    FLUSH,
    HOLD,
    FINISH
  } loader_state_t;

  typedef struct packed {
    logic [DDR_ADDR_W-1:0] addr;
    logic [DDR_WORD_W-1:0] din;
    logic [DDR_BE_W-1:0]   be;
  } ddr_wr_t;

  function automatic logic [DDR_BE_W-1:0] lane_mask(input logic [2:0] lane);
    return DDR_BE_W'(1) << lane;
  endfunction

endpackage

// File: rtl/ioctl_ddram_loader_if.sv
// ioctl download stream plus DDRAM write channel seen by the loader.
interface ioctl_ddram_loader_if;
  import ioctl_ddram_loader_pkg::*;

  logic                    ioctl_download;
  logic [7:0]              ioctl_index;
  logic                    ioctl_wr;
  logic [IOCTL_ADDR_W-1:0] ioctl_addr;
  logic [7:0]              ioctl_dout;
  logic                    ioctl_wait;

  logic                    ddram_busy;
  logic [DDR_ADDR_W-1:0]   ddram_addr;
  logic [DDR_WORD_W-1:0]   ddram_din;
  logic [DDR_BE_W-1:0]     ddram_be;
  logic                    ddram_we;
  logic [7:0]              ddram_burstcnt;

  // HPS and DDR side
  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, ddram_busy,
    input  ioctl_wait, ddram_addr, ddram_din, ddram_be, ddram_we, ddram_burstcnt
  );

  // Loader side
  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, ddram_busy,
    output ioctl_wait, ddram_addr, ddram_din, ddram_be, ddram_we, ddram_burstcnt
  );
endinterface

// File: rtl/ioctl_ddram_loader.sv
// Packs the ioctl byte stream into 64-bit words and writes them to DDRAM as
// single-beat bursts, stalling the HPS via ioctl_wait while a write is pending.
module ioctl_ddram_loader
  import ioctl_ddram_loader_pkg::*;
#(
  parameter logic [7:0]              INDEX      = CART_INDEX,
  parameter logic [DDR_ADDR_W-1:0]   BASE_WADDR = CART_BASE_WADDR,
  parameter logic [IOCTL_ADDR_W-1:0] MAX_BYTES  = CART_MAX_BYTES
) (
  input  logic                    sysclk,
  input  logic                    reset_n,
  ioctl_ddram_loader_if.slave     bus,
  output logic                    loaded,
  output logic [IOCTL_ADDR_W-1:0] size,
  output logic                    overflow
);

  loader_state_t state_q, state_d;

  logic                    active_q, end_seen_q, end_seen_d, start_pend_q, start_pend_d;
  logic [WORD_IDX_W-1:0]   cur_q, cur_d;
  logic [DDR_WORD_W-1:0]   buf_q, buf_d;
  logic [DDR_BE_W-1:0]     be_q, be_d;
  logic                    hold_pend_q, hold_pend_d;
  logic [7:0]              hold_byte_q, hold_byte_d;
  logic [IOCTL_ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [IOCTL_ADDR_W-1:0] size_q, size_d;
  logic                    ovf_q, ovf_d;
  logic                    wait_q, we_q, loaded_q;
  ddr_wr_t                 wr_q;

  logic                    active, rise, drop;
  logic [WORD_IDX_W-1:0]   in_word;
  logic [2:0]              in_lane, hold_lane;
  logic [IOCTL_ADDR_W-1:0] size_inc;

  assign active    = bus.ioctl_download && (bus.ioctl_index == INDEX);
  assign rise      = active && !active_q;
  assign in_word   = bus.ioctl_addr[IOCTL_ADDR_W-1:3];
  assign in_lane   = bus.ioctl_addr[2:0];
  assign hold_lane = hold_addr_q[2:0];
  assign drop      = bus.ioctl_addr > MAX_BYTES;
  assign size_inc  = bus.ioctl_addr + IOCTL_ADDR_W'(1);

  // Next-state, packer and bookkeeping logic
  always_comb begin
    state_d      = state_q;
    end_seen_d   = end_seen_q;
    start_pend_d = start_pend_q;
    cur_d        = cur_q;
    buf_d        = buf_q;
    be_d         = be_q;
    hold_pend_d  = hold_pend_q;
    hold_byte_d  = hold_byte_q;
    hold_addr_d  = hold_addr_q;
    size_d       = size_q;
    ovf_d        = ovf_q;

    // A new download that starts while busy is picked up once back in IDLE
    if (rise && state_q != IDLE) start_pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        end_seen_d = 1'b0;
        if (rise || start_pend_q) begin
          state_d      = FILL;
          start_pend_d = 1'b0;
          hold_pend_d  = 1'b0;
          cur_d        = '0;
          buf_d        = '0;
          be_d         = '0;
          size_d       = '0;
          ovf_d        = 1'b0;
        end
      end

      FILL: begin
        if (!active || end_seen_q) begin
          end_seen_d = 1'b1;
          state_d    = (be_q != '0) ? FLUSH : FINISH;
        end else if (bus.ioctl_wr) begin
          if (drop) begin
            ovf_d = 1'b1;
          end else begin
            if (size_inc > size_q) size_d = size_inc;
            if (in_word == cur_q || be_q == '0) begin
              cur_d                          = in_word;
              buf_d[{in_lane, 3'b000} +: 8]  = bus.ioctl_dout;
              be_d                           = be_q | lane_mask(in_lane);
              if (in_lane == 3'd7) state_d   = FLUSH;
            end else begin
              hold_byte_d = bus.ioctl_dout;
              hold_addr_d = bus.ioctl_addr;
              hold_pend_d = 1'b1;
              state_d     = FLUSH;
            end
          end
        end
      end

      FLUSH: begin
        if (!active) end_seen_d = 1'b1;
        if (!bus.ddram_busy) begin
          buf_d = '0;
          be_d  = '0;
          cur_d = cur_q + WORD_IDX_W'(1);
          if (hold_pend_q)                  state_d = HOLD;
          else if (end_seen_q || !active)   state_d = FINISH;
          else                              state_d = FILL;
        end
      end

      HOLD: begin
        if (!active) end_seen_d = 1'b1;
        hold_pend_d = 1'b0;
        cur_d       = hold_addr_q[IOCTL_ADDR_W-1:3];
        buf_d       = DDR_WORD_W'(hold_byte_q) << {hold_lane, 3'b000};
        be_d        = lane_mask(hold_lane);
        state_d     = (hold_lane == 3'd7) ? FLUSH : FILL;
      end

      FINISH: begin
        end_seen_d = 1'b0;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      active_q     <= 1'b0;
      end_seen_q   <= 1'b0;
      start_pend_q <= 1'b0;
      cur_q        <= '0;
      buf_q        <= '0;
      be_q         <= '0;
      hold_pend_q  <= 1'b0;
      hold_byte_q  <= '0;
      hold_addr_q  <= '0;
      size_q       <= '0;
      ovf_q        <= 1'b0;
      wait_q       <= 1'b0;
      we_q         <= 1'b0;
      loaded_q     <= 1'b0;
      wr_q         <= '{addr: BASE_WADDR, din: '0, be: '0};
    end else begin
      active_q     <= active;
      end_seen_q   <= end_seen_d;
      start_pend_q <= start_pend_d;
      cur_q        <= cur_d;
      buf_q        <= buf_d;
      be_q         <= be_d;
      hold_pend_q  <= hold_pend_d;
      hold_byte_q  <= hold_byte_d;
      hold_addr_q  <= hold_addr_d;
      size_q       <= size_d;
      ovf_q        <= ovf_d;
      wait_q       <= (state_d == FLUSH) || (state_d == HOLD);
      we_q         <= (state_d == FLUSH);
      loaded_q     <= (state_d == FINISH);
      // Write payload is captured on FLUSH entry and held until accepted
      if (state_d == FLUSH && state_q != FLUSH)
        wr_q <= '{addr: BASE_WADDR + DDR_ADDR_W'(cur_d), din: buf_d, be: be_d};
    end
  end

  assign bus.ioctl_wait     = wait_q;
  assign bus.ddram_we       = we_q;
  assign bus.ddram_addr     = wr_q.addr;
  assign bus.ddram_din      = wr_q.din;
  assign bus.ddram_be       = wr_q.be;
  assign bus.ddram_burstcnt = 8'd1;
  assign loaded             = loaded_q;
  assign size               = size_q;
  assign overflow           = ovf_q;

endmodule

// File: tb/tb_ioctl_ddram_loader.sv
// Directed bench for ioctl_ddram_loader: byte packing, stalls, jumps, overflow and reset.
module tb_ioctl_ddram_loader;
  import ioctl_ddram_loader_pkg::*;

  logic        sysclk;
  logic        reset_n;
  logic        loaded;
  logic [24:0] size;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lcnt   = 0;
  int we_cyc = 0;
  int wt_cyc = 0;

  logic [28:0] wa[$];
  logic [63:0] wd[$];
  logic [7:0]  wb[$];
  int          wc[$];

  ioctl_ddram_loader_if bus ();

  ioctl_ddram_loader dut (
    .sysclk   (sysclk),
    .reset_n  (reset_n),
    .bus      (bus),
    .loaded   (loaded),
    .size     (size),
    .overflow (overflow)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // DDR-side monitor: records every accepted write and pulse/level activity
  always @(posedge sysclk) begin
    cyc++;
    if (bus.ddram_we && !bus.ddram_busy) begin
      wa.push_back(bus.ddram_addr);
      wd.push_back(bus.ddram_din);
      wb.push_back(bus.ddram_be);
      wc.push_back(cyc);
    end
    if (loaded)         lcnt++;
    if (bus.ddram_we)   we_cyc++;
    if (bus.ioctl_wait) wt_cyc++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic clear_mon();
    wa.delete(); wd.delete(); wb.delete(); wc.delete();
    lcnt = 0; we_cyc = 0; wt_cyc = 0;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    @(negedge sysclk);
    bus.ioctl_index    = idx;
    bus.ioctl_download = 1'b1;
    @(negedge sysclk);
  endtask

  task automatic end_dl();
    @(negedge sysclk);
    bus.ioctl_download = 1'b0;
    repeat (12) @(negedge sysclk);
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    int n = 0;
    @(negedge sysclk);
    while (bus.ioctl_wait && n < 200) begin
      @(negedge sysclk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL send_byte_wait: ioctl_wait stuck high at addr %h", a);
    end
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    bus.ioctl_wr   = 1'b1;
    @(negedge sysclk);
    bus.ioctl_wr   = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (bus.ioctl_wait !== 1'b0) begin errors++; $display("FAIL rst_wait: got %b exp 0", bus.ioctl_wait); end
    checks++; if (bus.ddram_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b exp 0", bus.ddram_we); end
    checks++; if (bus.ddram_addr !== 29'h03C0_0000) begin errors++; $display("FAIL rst_addr: got %h exp 03c00000", bus.ddram_addr); end
    checks++; if (bus.ddram_din !== 64'h0) begin errors++; $display("FAIL rst_din: got %h exp 0", bus.ddram_din); end
    checks++; if (bus.ddram_be !== 8'h00) begin errors++; $display("FAIL rst_be: got %h exp 00", bus.ddram_be); end
    checks++; if (bus.ddram_burstcnt !== 8'd1) begin errors++; $display("FAIL rst_burstcnt: got %0d exp 1", bus.ddram_burstcnt); end
    checks++; if ({loaded, overflow} !== 2'b00) begin errors++; $display("FAIL rst_flags: got %b exp 00", {loaded, overflow}); end
    checks++; if (size !== 25'd0) begin errors++; $display("FAIL rst_size: got %0d exp 0", size); end
  endtask

  task automatic test_full_word();
    clear_mon();
    start_dl(8'd1);
    for (int i = 0; i < 8; i++) send_byte(25'(i), 8'(i));
    end_dl();
    checks++; if (wa.size() !== 1) begin errors++; $display("FAIL full_count: got %0d exp 1", wa.size()); end
    if (wa.size() > 0) begin
      checks++; if (wa[0] !== 29'h03C0_0000) begin errors++; $display("FAIL full_addr: got %h exp 03c00000", wa[0]); end
      checks++; if (wd[0] !== 64'h0706_0504_0302_0100) begin errors++; $display("FAIL full_din: got %h exp 0706050403020100", wd[0]); end
      checks++; if (wb[0] !== 8'hFF) begin errors++; $display("FAIL full_be: got %h exp ff", wb[0]); end
    end
    checks++; if (lcnt !== 1) begin errors++; $display("FAIL full_loaded: got %0d pulses exp 1", lcnt); end
    checks++; if (size !== 25'd8) begin errors++; $display("FAIL full_size: got %0d exp 8", size); end
  endtask

  task automatic test_partial_tail();
    int fall_cyc;
    clear_mon();
    start_dl(8'd1);
    for (int i = 0; i < 11; i++) send_byte(25'(i), 8'(8'h10 + i));
    @(negedge sysclk);
    fall_cyc = cyc;
    bus.ioctl_download = 1'b0;
    repeat (12) @(negedge sysclk);
    checks++; if (wa.size() !== 2) begin errors++; $display("FAIL tail_count: got %0d exp 2", wa.size()); end
    if (wa.size() > 1) begin
      checks++; if (wa[1] !== 29'h03C0_0001) begin errors++; $display("FAIL tail_addr: got %h exp 03c00001", wa[1]); end
      checks++; if (wb[1] !== 8'h07) begin errors++; $display("FAIL tail_be: got %h exp 07", wb[1]); end
      checks++; if (wd[1][23:0] !== 24'h1A1918) begin errors++; $display("FAIL tail_din: got %h exp 1a1918", wd[1][23:0]); end
      checks++; if (wc[1] <= fall_cyc) begin errors++; $display("FAIL tail_order: write cycle %0d not after fall %0d", wc[1], fall_cyc); end
    end
    checks++; if (size !== 25'd11) begin errors++; $display("FAIL tail_size: got %0d exp 11", size); end
    checks++; if (lcnt !== 1) begin errors++; $display("FAIL tail_loaded: got %0d pulses exp 1", lcnt); end
  endtask

  task automatic test_busy_stall();
    logic ok;
    clear_mon();
    start_dl(8'd1);
    for (int i = 0; i < 7; i++) send_byte(25'(i), 8'(8'h30 + i));
    bus.ddram_busy = 1'b1;
    send_byte(25'd7, 8'h37);
    for (int k = 0; k < 6; k++) begin
      ok = bus.ddram_we && bus.ioctl_wait && (bus.ddram_addr == 29'h03C0_0000) &&
           (bus.ddram_din == 64'h3736_3534_3332_3130) && (bus.ddram_be == 8'hFF);
      checks++;
      if (ok !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold cyc%0d: we=%b wait=%b addr=%h din=%h be=%h exp we=1 wait=1 addr=03c00000 din=3736353433323130 be=ff",
                 k, bus.ddram_we, bus.ioctl_wait, bus.ddram_addr, bus.ddram_din, bus.ddram_be);
      end
      if (k == 5) bus.ddram_busy = 1'b0;
      @(negedge sysclk);
    end
    checks++; if ({bus.ddram_we, bus.ioctl_wait} !== 2'b00) begin errors++; $display("FAIL stall_release: we/wait got %b exp 00", {bus.ddram_we, bus.ioctl_wait}); end
    end_dl();
    checks++; if (wa.size() !== 1) begin errors++; $display("FAIL stall_count: got %0d exp 1", wa.size()); end
  endtask

  task automatic test_overflow();
    clear_mon();
    start_dl(8'd1);
    send_byte(25'h1F_FFFF, 8'hCC);
    send_byte(25'h20_0000, 8'hDD);
    end_dl();
    checks++; if (wa.size() !== 1) begin errors++; $display("FAIL ovf_count: got %0d exp 1", wa.size()); end
    if (wa.size() > 0) begin
      checks++; if (wa[0] !== 29'h03C3_FFFF) begin errors++; $display("FAIL ovf_addr: got %h exp 03c3ffff", wa[0]); end
      checks++; if (wd[0] !== 64'hCC00_0000_0000_0000) begin errors++; $display("FAIL ovf_din: got %h exp cc00000000000000", wd[0]); end
      checks++; if (wb[0] !== 8'h80) begin errors++; $display("FAIL ovf_be: got %h exp 80", wb[0]); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b exp 1", overflow); end
    checks++; if (size !== 25'h20_0000) begin errors++; $display("FAIL ovf_size: got %h exp 200000", size); end
  endtask

  task automatic test_jump();
    clear_mon();
    start_dl(8'd1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL jump_ovf_clear: got %b exp 0", overflow); end
    send_byte(25'd0,  8'hA0);
    send_byte(25'd1,  8'hA1);
    send_byte(25'd16, 8'hB0);
    end_dl();
    checks++; if (wa.size() !== 2) begin errors++; $display("FAIL jump_count: got %0d exp 2", wa.size()); end
    if (wa.size() > 1) begin
      checks++; if (wa[0] !== 29'h03C0_0000 || wb[0] !== 8'h03 || wd[0] !== 64'hA1A0) begin
        errors++; $display("FAIL jump_w0: got addr %h be %h din %h exp 03c00000 03 a1a0", wa[0], wb[0], wd[0]); end
      checks++; if (wa[1] !== 29'h03C0_0002 || wb[1] !== 8'h01 || wd[1] !== 64'hB0) begin
        errors++; $display("FAIL jump_w1: got addr %h be %h din %h exp 03c00002 01 b0", wa[1], wb[1], wd[1]); end
    end
    checks++; if (size !== 25'd17) begin errors++; $display("FAIL jump_size: got %0d exp 17", size); end
    checks++; if (lcnt !== 1) begin errors++; $display("FAIL jump_loaded: got %0d pulses exp 1", lcnt); end
  endtask

  task automatic test_wrong_index();
    clear_mon();
    start_dl(8'd0);
    for (int i = 0; i < 16; i++) send_byte(25'(i), 8'(8'h60 + i));
    end_dl();
    checks++; if (we_cyc !== 0) begin errors++; $display("FAIL wav_we: got %0d we cycles exp 0", we_cyc); end
    checks++; if (wt_cyc !== 0) begin errors++; $display("FAIL wav_wait: got %0d wait cycles exp 0", wt_cyc); end
    checks++; if (lcnt !== 0) begin errors++; $display("FAIL wav_loaded: got %0d pulses exp 0", lcnt); end
    checks++; if (size !== 25'd17) begin errors++; $display("FAIL wav_size: got %0d exp 17", size); end
  endtask

  task automatic test_reset_flush();
    clear_mon();
    start_dl(8'd1);
    bus.ddram_busy = 1'b1;
    for (int i = 0; i < 8; i++) send_byte(25'(i), 8'(8'h40 + i));
    checks++; if (bus.ddram_we !== 1'b1) begin errors++; $display("FAIL rf_we_before: got %b exp 1", bus.ddram_we); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({bus.ddram_we, bus.ioctl_wait} !== 2'b00) begin errors++; $display("FAIL rf_async: we/wait got %b exp 00", {bus.ddram_we, bus.ioctl_wait}); end
    bus.ioctl_download = 1'b0;
    bus.ddram_busy     = 1'b0;
    repeat (2) @(negedge sysclk);
    reset_n = 1'b1;
    repeat (2) @(negedge sysclk);
    checks++; if (wa.size() !== 0 || lcnt !== 0) begin errors++; $display("FAIL rf_nowrite: writes %0d loaded %0d exp 0 0", wa.size(), lcnt); end
    checks++; if (size !== 25'd0) begin errors++; $display("FAIL rf_size: got %0d exp 0", size); end
    start_dl(8'd1);
    for (int i = 0; i < 8; i++) send_byte(25'(i), 8'(8'h50 + i));
    end_dl();
    checks++; if (wa.size() !== 1) begin errors++; $display("FAIL rf_count: got %0d exp 1", wa.size()); end
    if (wa.size() > 0) begin
      checks++; if (wa[0] !== 29'h03C0_0000 || wd[0] !== 64'h5756_5554_5352_5150 || wb[0] !== 8'hFF) begin
        errors++; $display("FAIL rf_write: got addr %h din %h be %h exp 03c00000 5756555453525150 ff", wa[0], wd[0], wb[0]); end
    end
    checks++; if (lcnt !== 1) begin errors++; $display("FAIL rf_loaded: got %0d pulses exp 1", lcnt); end
  endtask

  initial begin
    reset_n            = 1'b0;
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    bus.ddram_busy     = 1'b0;
    repeat (3) @(negedge sysclk);
    test_reset();
    reset_n = 1'b1;
    @(negedge sysclk);
    test_full_word();
    test_partial_tail();
    test_busy_stall();
    test_overflow();
    test_jump();
    test_wrong_index();
    test_reset_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
